// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-memory path: loader state encoding,
// word type, and processor opcode constants.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

  localparam int WORD_BYTES = 4;

  typedef logic [31:0] word_t;

  localparam logic [5:0] OP_R  = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_J  = 6'b000010;

  // Byte address of word idx in a region starting at base.
  function automatic word_t word_addr(input word_t base, input logic [10:0] idx);
    return base + {19'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Big-endian 8->32 packer: the oldest byte ends up in bits [31:24] after four shifts.
import mips_pkg::*;

module byte_assembler (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       shift,
  input  logic [7:0] byte_data,
  output word_t      word,
  output logic       word_full
);

  logic [1:0] cnt_r;
  word_t      wbuf_r;

  // Shift register and byte counter; the counter wraps to 0 after the fourth byte.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_r  <= 2'd0;
      wbuf_r <= 32'h0000_0000;
    end else if (shift) begin
      cnt_r  <= cnt_r + 2'd1;
      wbuf_r <= {wbuf_r[23:0], byte_data};
    end else begin
      cnt_r  <= cnt_r;
      wbuf_r <= wbuf_r;
    end
  end

  assign word      = wbuf_r;
  // Three bytes are buffered, so the next shift completes a word.
  assign word_full = (cnt_r == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a byte stream into words, writes them from BASE_ADDR
// upward and keeps the CPU held until a complete, error-free image is in memory.
import mips_pkg::*;

module imem_loader #(
  parameter word_t BASE_ADDR = 32'h0000_0000,
  parameter int    DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [10:0] word_count
);

  localparam logic [10:0] DEPTH_W = 11'(DEPTH);

  loader_state_e state_r, state_s;
  logic          we_r;
  word_t         addr_r;
  logic          done_r, err_r, last_r;
  logic [10:0]   word_count_r;

  logic          clear_s, shift_s, write_s, set_err_s, set_done_s;
  word_t         asm_word_s;
  logic          asm_full_s;

  byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_s),
    .shift     (shift_s),
    .byte_data (byte_data),
    .word      (asm_word_s),
    .word_full (asm_full_s)
  );

  // Next-state and per-cycle control decode.
  always_comb begin
    state_s    = state_r;
    clear_s    = 1'b0;
    shift_s    = 1'b0;
    write_s    = 1'b0;
    set_err_s  = 1'b0;
    set_done_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_LOAD;
          clear_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: begin
        if (byte_valid) begin
          // Overflow is trapped before the byte is considered part of a word.
          if (word_count_r == DEPTH_W) begin
            state_s   = ST_DONE;
            set_err_s = 1'b1;
          end else if (asm_full_s) begin
            state_s = ST_WRITE;
            shift_s = 1'b1;
            write_s = 1'b1;
          end else if (byte_last) begin
            state_s   = ST_DONE;
            set_err_s = 1'b1;
          end else begin
            shift_s = 1'b1;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (last_r) begin
          state_s    = ST_DONE;
          set_done_s = 1'b1;
        end else begin
          state_s = ST_LOAD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, write port and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      we_r         <= 1'b0;
      addr_r       <= BASE_ADDR;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      last_r       <= 1'b0;
      word_count_r <= 11'd0;
    end else begin
      state_r <= state_s;
      we_r    <= write_s;
      if (write_s) begin
        addr_r <= word_addr(BASE_ADDR, word_count_r);
        last_r <= byte_last;
      end else begin
        addr_r <= addr_r;
        last_r <= last_r;
      end
      if (clear_s) begin
        word_count_r <= 11'd0;
        done_r       <= 1'b0;
        err_r        <= 1'b0;
      end else begin
        word_count_r <= (state_r == ST_WRITE) ? word_count_r + 11'd1 : word_count_r;
        done_r       <= done_r | set_done_s;
        err_r        <= err_r | set_err_s;
      end
    end
  end

  assign byte_ready = (state_r == ST_LOAD);
  assign cpu_hold   = (state_r != ST_DONE) | err_r;
  assign imem_we    = we_r;
  assign imem_addr  = addr_r;
  assign imem_wdata = asm_word_s;
  assign done       = done_r;
  assign err        = err_r;
  assign word_count = word_count_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: reset checks, a vector table of short images,
// hand-written corner sequences and randomized streams against a stream-level model.
module tb_imem_loader;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT 0 (DEPTH 1024) and DUT 1 (DEPTH 4) have independent stimulus.
  logic start = 1'b0, byte_valid = 1'b0, byte_last = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic byte_ready, imem_we, cpu_hold, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [10:0] word_count;

  logic s_start = 1'b0, s_byte_valid = 1'b0, s_byte_last = 1'b0;
  logic [7:0] s_byte_data = 8'h00;
  logic s_byte_ready, s_imem_we, s_cpu_hold, s_done, s_err;
  logic [31:0] s_imem_addr, s_imem_wdata;
  logic [10:0] s_word_count;

  imem_loader u_dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .err(err), .word_count(word_count)
  );

  imem_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .byte_valid(s_byte_valid), .byte_data(s_byte_data),
    .byte_last(s_byte_last), .byte_ready(s_byte_ready), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
    .imem_wdata(s_imem_wdata), .cpu_hold(s_cpu_hold), .done(s_done), .err(s_err), .word_count(s_word_count)
  );

  int total = 0;
  int bad = 0;

  logic [7:0]  tx_data [64];
  logic        tx_last [64];
  logic [63:0] cap0[$];
  logic [63:0] cap1[$];
  logic [31:0] mem0 [1024];

  logic [63:0] exp_q[$];
  logic        exp_err, exp_done;
  int          exp_wc, exp_acc;

  typedef struct {
    int          n;
    logic [63:0] data;
    int          last_at;
    int          exp_writes;
    logic [31:0] exp_w0;
    logic        exp_err;
    logic [10:0] exp_wc;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Capture every write strobe of both DUTs, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      cap0.push_back({imem_addr, imem_wdata});
      if (imem_addr < 32'd4096) mem0[imem_addr[11:2]] <= imem_wdata;
    end
    if (s_imem_we === 1'b1) cap1.push_back({s_imem_addr, s_imem_wdata});
  end

  task automatic set_in(input bit sel, input logic v, input logic [7:0] d, input logic l);
    if (sel) begin
      s_byte_valid = v; s_byte_data = d; s_byte_last = l;
    end else begin
      byte_valid = v; byte_data = d; byte_last = l;
    end
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) s_start = 1'b1; else start = 1'b1;
    @(negedge clk);
    s_start = 1'b0; start = 1'b0;
  endtask

  // Offer tx_data[0..n-1]; stops early once the DUT reports done or err.
  task automatic send(input bit sel, input int n, input bit gaps, output int acc);
    int i = 0;
    int budget = 0;
    bit v, rdy;
    while (i < n && budget < 1000) begin
      @(negedge clk);
      if (sel ? (s_done | s_err) : (done | err)) break;
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      rdy = sel ? s_byte_ready : byte_ready;
      set_in(sel, v, v ? tx_data[i] : 8'($urandom), v ? tx_last[i] : 1'b0);
      @(posedge clk);
      if (v && rdy) i++;
      budget++;
    end
    @(negedge clk);
    set_in(sel, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (sel ? (s_done | s_err) : (done | err)) break;
      @(negedge clk);
    end
    acc = i;
  endtask

  task automatic clear_tx();
    for (int k = 0; k < 64; k++) begin
      tx_data[k] = 8'h00;
      tx_last[k] = 1'b0;
    end
  endtask

  // Stream-level reference: consume bytes in order, four per word, honouring last and depth.
  task automatic model_run(input int depth, input int n);
    logic [31:0] w;
    int nb;
    w = 32'h0; nb = 0;
    exp_q.delete(); exp_err = 1'b0; exp_done = 1'b0; exp_wc = 0; exp_acc = n;
    for (int k = 0; k < n; k++) begin
      if (exp_wc == depth) begin
        exp_err = 1'b1; exp_acc = k + 1; break;
      end
      w = (w << 8) | 32'(tx_data[k]);
      nb++;
      if (nb == 4) begin
        exp_q.push_back({32'(exp_wc * 4), w});
        exp_wc++;
        nb = 0;
        if (tx_last[k]) begin
          exp_done = 1'b1; exp_acc = k + 1; break;
        end
      end else if (tx_last[k]) begin
        exp_err = 1'b1; exp_acc = k + 1; break;
      end
    end
  endtask

  task automatic compare_writes(input bit sel, input string tag);
    int sz;
    logic [63:0] got;
    sz = sel ? cap1.size() : cap0.size();
    check({tag, "_nwrites"}, 32'(sz), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < sz; j++) begin
      got = sel ? cap1[j] : cap0[j];
      check({tag, "_addr"}, got[63:32], exp_q[j][63:32]);
      check({tag, "_data"}, got[31:0], exp_q[j][31:0]);
    end
  endtask

  initial begin
    int acc;
    int n;
    bit sel;
    logic [31:0] prog [3];

    vecs[0] = '{4, 64'h00006020_00000000, 3, 1, 32'h00006020, 1'b0, 11'd1};
    vecs[1] = '{2, 64'h8C010000_00000000, 1, 0, 32'h00000000, 1'b1, 11'd0};
    vecs[2] = '{1, 64'h55000000_00000000, 0, 0, 32'h00000000, 1'b1, 11'd0};
    vecs[3] = '{3, 64'hA1B2C300_00000000, 2, 0, 32'h00000000, 1'b1, 11'd0};
    vecs[4] = '{8, 64'hAC220004_0800000A, 7, 2, 32'hAC220004, 1'b0, 11'd2};
    vecs[5] = '{5, 64'h01234567_89000000, 4, 1, 32'h01234567, 1'b1, 11'd1};

    // Reset for two cycles, then idle.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_wc", 32'(word_count), 32'd0);

    // Vector table of short images on the deep DUT.
    for (int t = 0; t < 6; t++) begin
      clear_tx();
      for (int k = 0; k < vecs[t].n; k++) tx_data[k] = vecs[t].data[63 - 8*k -: 8];
      tx_last[vecs[t].last_at] = 1'b1;
      cap0.delete();
      pulse_start(1'b0);
      send(1'b0, vecs[t].n, 1'b0, acc);
      check($sformatf("vec%0d_nwrites", t), 32'(cap0.size()), 32'(vecs[t].exp_writes));
      if (vecs[t].exp_writes > 0 && cap0.size() > 0) begin
        check($sformatf("vec%0d_addr0", t), cap0[0][63:32], 32'h0);
        check($sformatf("vec%0d_data0", t), cap0[0][31:0], vecs[t].exp_w0);
      end
      check($sformatf("vec%0d_err", t), 32'(err), 32'(vecs[t].exp_err));
      check($sformatf("vec%0d_done", t), 32'(done), 32'(!vecs[t].exp_err));
      check($sformatf("vec%0d_hold", t), 32'(cpu_hold), 32'(vecs[t].exp_err));
      check($sformatf("vec%0d_wc", t), 32'(word_count), 32'(vecs[t].exp_wc));
      check($sformatf("vec%0d_ready", t), 32'(byte_ready), 32'd0);
    end

    // Three-word program with random valid gaps.
    prog[0] = 32'h00006020; prog[1] = 32'hAC0C0004; prog[2] = 32'h0800000A;
    clear_tx();
    for (int k = 0; k < 12; k++) begin
      tx_data[k] = prog[k / 4][31 - 8*(k % 4) -: 8];
    end
    tx_last[11] = 1'b1;
    cap0.delete();
    pulse_start(1'b0);
    send(1'b0, 12, 1'b1, acc);
    check("prog_nwrites", 32'(cap0.size()), 32'd3);
    for (int j = 0; j < 3 && j < cap0.size(); j++) begin
      check("prog_addr", cap0[j][63:32], 32'(j * 4));
      check("prog_data", cap0[j][31:0], prog[j]);
    end
    @(negedge clk);
    for (int j = 0; j < 3; j++) check("prog_mem", mem0[j], prog[j]);
    check("prog_wc", 32'(word_count), 32'd3);
    check("prog_done", 32'(done), 32'd1);

    // Overflow on the DEPTH=4 DUT: five words offered.
    clear_tx();
    for (int k = 0; k < 20; k++) tx_data[k] = 8'(k + 16);
    tx_last[19] = 1'b1;
    cap1.delete();
    pulse_start(1'b1);
    send(1'b1, 20, 1'b0, acc);
    check("ovf_accepted", 32'(acc), 32'd17);
    check("ovf_nwrites", 32'(cap1.size()), 32'd4);
    for (int j = 0; j < 4 && j < cap1.size(); j++) check("ovf_addr", cap1[j][63:32], 32'(j * 4));
    check("ovf_err", 32'(s_err), 32'd1);
    check("ovf_done", 32'(s_done), 32'd0);
    check("ovf_hold", 32'(s_cpu_hold), 32'd1);
    check("ovf_wc", 32'(s_word_count), 32'd4);

    // Reset in the middle of a load (6 bytes in), then a fresh one-word load.
    clear_tx();
    for (int k = 0; k < 6; k++) tx_data[k] = 8'(8'hC0 + k);
    pulse_start(1'b0);
    send(1'b0, 6, 1'b0, acc);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mid_rst_ready", 32'(byte_ready), 32'd0);
    check("mid_rst_we", 32'(imem_we), 32'd0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_wdata", imem_wdata, 32'h0);
    check("mid_rst_hold", 32'(cpu_hold), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_wc", 32'(word_count), 32'd0);
    clear_tx();
    tx_data[0] = 8'h8C; tx_data[1] = 8'h22; tx_data[2] = 8'h00; tx_data[3] = 8'h10;
    tx_last[3] = 1'b1;
    cap0.delete();
    pulse_start(1'b0);
    send(1'b0, 4, 1'b0, acc);
    check("after_rst_nwrites", 32'(cap0.size()), 32'd1);
    if (cap0.size() > 0) begin
      check("after_rst_addr", cap0[0][63:32], 32'h0);
      check("after_rst_data", cap0[0][31:0], 32'h8C220010);
    end
    check("after_rst_wc", 32'(word_count), 32'd1);

    // Randomized streams on both DUTs against the model.
    for (int it = 0; it < 24; it++) begin
      sel = it[0];
      n = ($urandom_range(0, 1) == 0) ? 4 * $urandom_range(1, 6) : $urandom_range(1, 24);
      clear_tx();
      for (int k = 0; k < n; k++) tx_data[k] = 8'($urandom);
      tx_last[n - 1] = 1'b1;
      model_run(sel ? 4 : 1024, n);
      cap0.delete(); cap1.delete();
      pulse_start(sel);
      send(sel, n, 1'b1, acc);
      check("rnd_accepted", 32'(acc), 32'(exp_acc));
      compare_writes(sel, "rnd");
      check("rnd_err", 32'(sel ? s_err : err), 32'(exp_err));
      check("rnd_done", 32'(sel ? s_done : done), 32'(exp_done));
      check("rnd_wc", 32'(sel ? s_word_count : word_count), 32'(exp_wc));
      check("rnd_hold", 32'(sel ? s_cpu_hold : cpu_hold), 32'(!exp_done));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
